data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressed, little-endian data memory for the RISC-V core load/store path.
- Generalises the single-cycle word memory:
  - parametrised depth and wait states
  - valid/ready request and response handshakes
  - byte/half/word access with sign or zero extension on loads
  - misaligned and out-of-range access detection
- Sits between the core's LSU stage and data storage. Stall and trap logic use rsp_valid and rsp_err.

Parameters:
- SIZE, 4096: memory depth in bytes. Must be a power of two, >= 4. ADDR_BITS = $clog2(SIZE).
- WAIT_STATES, 0: extra cycles inserted between request acceptance and response. Range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low bytes used per size
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  access was misaligned, out of range, or reserved size

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, req_ready=0 during reset then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory array is not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid: accept, go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: req_ready=0. Counter counts 0..WAIT_STATES-1. At the last count go to RESP.
  - RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable. On rsp_ready go to IDLE.
- req_ready is a registered function of state only and never depends combinationally on req_valid or rsp_ready.
- Latency: rsp_valid rises exactly 1+WAIT_STATES cycles after the acceptance edge. Throughput is at most one request per 2+WAIT_STATES cycles.
- Error detection, evaluated at acceptance:
  - err if req_size==3
  - err if size==1 and addr[0]!=0
  - err if size==2 and addr[1:0]!=0
  - err if addr[31:ADDR_BITS]!=0
- On error: no memory write, rsp_rdata=0, rsp_err=1.
- Store commit: at the acceptance edge, when there is no error.
  - Byte lanes: size 0 writes addr; size 1 writes addr, addr+1; size 2 writes addr..addr+3.
  - Lane k takes wdata[8k+7:8k].
  - Aligned accesses never wrap.
  - Store response: rdata=0, err=0.
- Load capture: bytes are read at the acceptance edge, then extended and registered into a response buffer.
  - Byte load: rdata = {24{unsigned?0:b[7]}, b}.
  - Half load: rdata = {16{unsigned?0:h[15]}, h}.
  - Word load: rdata = the word unchanged; req_unsigned is ignored.
- Ordering: a load accepted after a store observes the stored data. This follows because the store commits before any later acceptance.
- Inputs are ignored when not accepted. Changing the req_* fields while req_ready=0 has no effect.
- Reset mid-operation (WAIT or RESP):
  - The pending response is discarded; return to IDLE.
  - An already-committed store remains in memory.
- rsp_ready held high in RESP: the response completes in a single RESP cycle, and the next request can be accepted one cycle later in IDLE.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid exactly 1 cycle after acceptance.
- Store byte 0x80 @0x21, then:
  - load byte signed @0x21 -> 0xFFFFFF80
  - load byte unsigned @0x21 -> 0x00000080
  - load half signed @0x20 -> 0xFFFF80xx, where xx is the prior byte @0x20
- Misaligned half store @0x31 with wdata 0x1234 -> err=1, rdata=0. A following word load @0x30 returns the unchanged prior contents.
- Out of range and reserved size:
  - SIZE=4096, word load @0x1000 -> err=1
  - req_size=3 -> err=1
  - no writes occur in either case
- WAIT_STATES=3, rsp_ready held low for 5 cycles:
  - rsp_valid rises 4 cycles after acceptance and stays high with stable data until rsp_ready.
  - req_ready=0 throughout.
- Assert rst_n low during WAIT after a store to @0x40:
  - rsp_valid never rises; req_ready returns to 1 after reset.
  - A subsequent load @0x40 returns the stored value.

Source files
------------

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressed little-endian data memory with valid/ready handshakes
// Byte/half/word access, load extension, misaligned/range errors, configurable wait states.
module data_memory #(
   parameter int SIZE        = 4096,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int ADDR_BITS = $clog2(SIZE);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                 state;
   logic [3:0]             wait_cnt;
   logic [7:0]             mem [SIZE];

   logic                   accept;
   logic                   req_err;
   logic [ADDR_BITS-1:0]   a0;
   logic [ADDR_BITS-1:0]   lane_idx [4];
   logic [3:0]             byte_en;
   logic [31:0]            read_word;
   logic [31:0]            read_shifted;
   logic [31:0]            write_shifted;
   logic [31:0]            load_data;

   assign accept = req_valid && req_ready;
   assign a0     = req_addr[ADDR_BITS-1:0];

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         2'd0:    req_err = 1'b0;
         2'd1:    req_err = req_addr[0];
         2'd2:    req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if ((req_addr >> ADDR_BITS) != 32'd0)
         req_err = 1'b1;
   end

   // All lanes live in the aligned word line containing the address.
   always_comb begin
      for (int k = 0; k < 4; k++)
         lane_idx[k] = (a0 & ~ADDR_BITS'(3)) | ADDR_BITS'(k);
   end

   assign read_word     = {mem[lane_idx[3]], mem[lane_idx[2]], mem[lane_idx[1]], mem[lane_idx[0]]};
   assign read_shifted  = read_word >> {a0[1:0], 3'b000};
   assign write_shifted = req_wdata << {a0[1:0], 3'b000};

   always_comb begin
      byte_en = 4'b0000;
      case (req_size)
         2'd0:    byte_en = 4'b0001 << a0[1:0];
         2'd1:    byte_en = 4'b0011 << a0[1:0];
         2'd2:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   always_comb begin
      load_data = read_word;
      case (req_size)
         2'd0:    load_data = {{24{~req_unsigned & read_shifted[7]}}, read_shifted[7:0]};
         2'd1:    load_data = {{16{~req_unsigned & read_shifted[15]}}, read_shifted[15:0]};
         default: load_data = read_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int k = 0; k < 4; k++)
            if (byte_en[k])
               mem[lane_idx[k]] <= write_shifted[8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         wait_cnt  <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  rsp_rdata <= (req_we || req_err) ? 32'd0 : load_data;
                  rsp_err   <= req_err;
                  req_ready <= 1'b0;
                  wait_cnt  <= 4'd0;
                  if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                  end else begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory (WAIT_STATES 0 and 3 instances)
module tb_data_memory;

   logic        clk;
   logic        rst_n;
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_we       [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [31:0] req_addr     [2];
   logic [31:0] req_wdata    [2];
   logic        rsp_valid    [2];
   logic        rsp_ready    [2];
   logic [31:0] rsp_rdata    [2];
   logic        rsp_err      [2];

   int checks = 0;
   int errors = 0;
   int ws_of [2] = '{0, 3};

   logic [7:0] ref_mem [2][4096];

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [20];

   data_memory #(.SIZE(4096), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   data_memory #(.SIZE(4096), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain byte-array arithmetic straight from the access rules.
   function automatic void model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] val;
      n  = 1 << sz;
      er = (sz == 2'd3) || (addr >= 32'd4096) || ((addr % n) != 0);
      rd = 32'd0;
      if (er) return;
      if (we) begin
         for (int k = 0; k < n; k++)
            ref_mem[d][addr + k] = wdata[8*k +: 8];
      end else begin
         val = 32'd0;
         for (int k = 0; k < n; k++)
            val = val | (32'(ref_mem[d][addr + k]) << (8 * k));
         if (!uns && n < 4 && val[8*n-1])
            val = val | (32'hFFFF_FFFF << (8 * n));
         rd = val;
      end
   endfunction

   task automatic do_req(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rd, output logic er, output int lat);
      int t;
      t = 0;
      while (!req_ready[d] && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!req_ready[d]) check("req_ready_timeout", 32'(req_ready[d]), 32'd1);
      req_valid[d]    = 1'b1;
      req_we[d]       = we;
      req_size[d]     = sz;
      req_unsigned[d] = uns;
      req_addr[d]     = addr;
      req_wdata[d]    = wdata;
      @(posedge clk); #1;
      req_valid[d]    = 1'b0;
      req_we[d]       = 1'($urandom);
      req_addr[d]     = $urandom;
      req_wdata[d]    = $urandom;
      lat = 1;
      while (!rsp_valid[d] && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rsp_rdata[d];
      er = rsp_err[d];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid[d]), 32'd1);
         check("hold_rdata", rsp_rdata[d], rd);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[d] = 1'b0;
      check("after_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("after_rsp_ready", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      logic [31:0] rd, exp_rd, addr, wd;
      logic        er, exp_er, we, uns, saw_valid, saw_ready;
      logic [1:0]  sz;
      int          lat;

      tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h20,   32'h11223344, 32'h0,        1'b0};
      tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h21,   32'hABCDEF80, 32'h0,        1'b0};
      tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0};
      tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h21,   32'h0,        32'h00000080, 1'b0};
      tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h20,   32'h0,        32'hFFFF8044, 1'b0};
      tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h20,   32'h0,        32'h00008044, 1'b0};
      tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h30,   32'hCAFEF00D, 32'h0,        1'b0};
      tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h31,   32'h00001234, 32'h0,        1'b1};
      tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h30,   32'h0,        32'hCAFEF00D, 1'b0};
      tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h00,   32'h55555555, 32'h0,        1'b0};
      tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, 32'h0,        1'b1};
      tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
      tbl[14] = '{1'b1, 2'd3, 1'b0, 32'h30,   32'h00000000, 32'h0,        1'b1};
      tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h00,   32'h0,        32'h55555555, 1'b0};
      tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h30,   32'h0,        32'hCAFEF00D, 1'b0};
      tbl[17] = '{1'b0, 2'd0, 1'b0, 32'h23,   32'h0,        32'h00000011, 1'b0};
      tbl[18] = '{1'b0, 2'd1, 1'b0, 32'h22,   32'h0,        32'h00001122, 1'b0};
      tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h22,   32'h0,        32'h0,        1'b1};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
         req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_req_ready", 32'(req_ready[d]), 32'd0);
         check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
         check("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
         check("ready_after_reset", 32'(req_ready[d]), 32'd1);

      // Preload the low 256 bytes so every later load has a known reference.
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 256; a += 4) begin
            wd = $urandom;
            model(d, 1'b1, 2'd2, 1'b0, 32'(a), wd, exp_rd, exp_er);
            do_req(d, 1'b1, 2'd2, 1'b0, 32'(a), wd, 0, rd, er, lat);
            check("preload_err", 32'(er), 32'd0);
         end
      end

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 20; i++) begin
            model(d, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, exp_rd, exp_er);
            do_req(d, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 0, rd, er, lat);
            check($sformatf("tbl%0d_d%0d_rdata", i, d), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_d%0d_err", i, d), 32'(er), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_d%0d_latency", i, d), 32'(lat), 32'(1 + ws_of[d]));
         end
      end

      // WAIT_STATES=3, response held back; request fields wiggle while not ready.
      model(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, exp_rd, exp_er);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
      req_addr[1] = 32'h10;
      @(posedge clk); #1;
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_wdata[1] = 32'h0BAD0BAD;
      lat = 1;
      while (!rsp_valid[1] && lat < 50) begin
         check("hold_wait_req_ready", 32'(req_ready[1]), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check("hold_latency", 32'(lat), 32'd4);
      for (int h = 0; h < 5; h++) begin
         check("hold_rsp_valid", 32'(rsp_valid[1]), 32'd1);
         check("hold_rsp_rdata", rsp_rdata[1], exp_rd);
         check("hold_req_ready", 32'(req_ready[1]), 32'd0);
         @(posedge clk); #1;
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      check("hold_release_valid", 32'(rsp_valid[1]), 32'd0);
      do_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
      check("ignored_store_rdata", rd, exp_rd);

      // Reset during WAIT after a store commits.
      wd = 32'hA5C3_1E0F;
      model(1, 1'b1, 2'd2, 1'b0, 32'h40, wd, exp_rd, exp_er);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h40;
      req_wdata[1] = wd;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready[1]), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw_valid = 1'b0;
      saw_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (rsp_valid[1]) saw_valid = 1'b1;
         if (req_ready[1]) saw_ready = 1'b1;
      end
      check("midrst_no_rsp", 32'(saw_valid), 32'd0);
      check("midrst_ready_back", 32'(saw_ready), 32'd1);
      do_req(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, rd, er, lat);
      check("midrst_store_kept", rd, wd);

      // Randomized traffic against the reference model.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 150; i++) begin
            sz  = 2'($urandom_range(0, 3));
            we  = 1'($urandom);
            uns = 1'($urandom);
            wd  = $urandom;
            if ($urandom_range(0, 9) == 0)
               addr = 32'h1000 + $urandom_range(0, 32'h0FFF_FFFF);
            else begin
               addr = 32'($urandom_range(0, 255));
               if ($urandom_range(0, 4) != 0 && sz != 2'd3)
                  addr = addr & ~32'((1 << sz) - 1);
            end
            model(d, we, sz, uns, addr, wd, exp_rd, exp_er);
            do_req(d, we, sz, uns, addr, wd, $urandom_range(0, 2), rd, er, lat);
            check($sformatf("rand_d%0d_rdata a=%h sz=%0d we=%0d", d, addr, sz, we), rd, exp_rd);
            check($sformatf("rand_d%0d_err a=%h sz=%0d", d, addr, sz), 32'(er), 32'(exp_er));
            check($sformatf("rand_d%0d_latency", d), 32'(lat), 32'(1 + ws_of[d]));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
